block_accumulator: RTL and testbench

BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

---
 rtl/block_accumulator_pkg.sv | 16 +
 rtl/block_accumulator_if.sv | 30 +++
 rtl/block_accumulator_reduce_datapath.sv | 31 +++
 rtl/block_accumulator.sv | 129 ++++++++++++
 tb/tb_block_accumulator.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/block_accumulator_pkg.sv
// Shared definitions for the block reduction path: state encoding and
// default geometry, also consumed by the multiplier stage.
package block_accumulator_pkg;

   localparam int DEF_LOGDEPTH = 6;
   localparam int DEF_WIDTH    = 32;
   localparam int DEF_TIMEOUT  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } acc_state_e;

endpackage

// File: rtl/block_accumulator_if.sv
// Handshake and result bundle between the accumulator, the block-stream
// producer and the result consumer. The accumulator sits on the slave side.
interface block_accumulator_if #(
   parameter int LOGDEPTH = block_accumulator_pkg::DEF_LOGDEPTH,
   parameter int WIDTH    = block_accumulator_pkg::DEF_WIDTH
);
   logic                  start;
   logic                  busy;
   logic                  EN_blockRead;
   logic                  VALID_memVal;
   logic [WIDTH-1:0]      memVal_data;
   logic [WIDTH+LOGDEPTH-1:0] sum_out;
   logic [WIDTH-1:0]      max_out;
   logic [LOGDEPTH:0]     count_out;
   logic                  result_valid;
   logic                  result_ready;
   logic                  err_short;

   modport slave (
      input  start, VALID_memVal, memVal_data, result_ready,
      output busy, EN_blockRead, sum_out, max_out, count_out,
             result_valid, err_short
   );

   modport master (
      output start, VALID_memVal, memVal_data, result_ready,
      input  busy, EN_blockRead, sum_out, max_out, count_out,
             result_valid, err_short
   );
endinterface

// File: rtl/block_accumulator_reduce_datapath.sv
// Sum / max / count registers for one block. clear wins over accept so a
// fresh block always starts from zero.
module reduce_datapath #(
   parameter int LOGDEPTH = block_accumulator_pkg::DEF_LOGDEPTH,
   parameter int WIDTH    = block_accumulator_pkg::DEF_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      accept,
   input  logic [WIDTH-1:0]          data,
   output logic [WIDTH+LOGDEPTH-1:0] sum,
   output logic [WIDTH-1:0]          max,
   output logic [LOGDEPTH:0]         count
);

   // Accumulate accepted words; the extra LOGDEPTH sum bits absorb N words.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sum   <= '0;
         max   <= '0;
         count <= '0;
      end else if (accept) begin
         sum   <= sum + {{LOGDEPTH{1'b0}}, data};
         if (data > max)
            max <= data;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/block_accumulator.sv
// Block accumulator: requests one block stream, reduces it to sum/max/count,
// and holds the result until the consumer takes it. A stream that stalls for
// TIMEOUT cycles ends the block early with err_short.
module block_accumulator
   import block_accumulator_pkg::*;
#(
   parameter int LOGDEPTH = DEF_LOGDEPTH,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   block_accumulator_if.slave  bus
);

   localparam int N  = 1 << LOGDEPTH;
   localparam int CW = LOGDEPTH + 1;
   localparam int IW = $clog2(TIMEOUT + 1);

   acc_state_e state, next_state;

   logic                      clear, accept;
   logic                      idle_clr, idle_inc, set_err;
   logic [IW-1:0]             idle_cnt;
   logic                      busy_q, en_q, rv_q, err_q;
   logic [WIDTH+LOGDEPTH-1:0] sum;
   logic [WIDTH-1:0]          max;
   logic [CW-1:0]             count;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state and datapath control. The final accept and the timeout both
   // leave ACCUM on the same edge, so nothing past word N is ever taken.
   always_comb begin
      next_state = state;
      clear      = 1'b0;
      accept     = 1'b0;
      idle_clr   = 1'b0;
      idle_inc   = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               clear      = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            next_state = ACCUM;
         end
         ACCUM: begin
            if (bus.VALID_memVal) begin
               accept   = 1'b1;
               idle_clr = 1'b1;
               if (count == CW'(N - 1))
                  next_state = DONE;
            end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
               set_err    = 1'b1;
               next_state = DONE;
            end else begin
               idle_inc = 1'b1;
            end
         end
         DONE: begin
            if (bus.result_ready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Consecutive idle-cycle counter inside ACCUM.
   always_ff @(posedge clk) begin
      if (rst || clear || idle_clr)
         idle_cnt <= '0;
      else if (idle_inc)
         idle_cnt <= idle_cnt + 1'b1;
   end

   // Status outputs registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         en_q   <= 1'b0;
         rv_q   <= 1'b0;
      end else begin
         busy_q <= (next_state != IDLE);
         en_q   <= (next_state == REQ);
         rv_q   <= (next_state == DONE);
      end
   end

   // Short-block flag; cleared when a new block starts.
   always_ff @(posedge clk) begin
      if (rst || clear)
         err_q <= 1'b0;
      else if (set_err)
         err_q <= 1'b1;
   end

   reduce_datapath #(
      .LOGDEPTH (LOGDEPTH),
      .WIDTH    (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .accept (accept),
      .data   (bus.memVal_data),
      .sum    (sum),
      .max    (max),
      .count  (count)
   );

   assign bus.busy         = busy_q;
   assign bus.EN_blockRead = en_q;
   assign bus.result_valid = rv_q;
   assign bus.err_short    = err_q;
   assign bus.sum_out      = sum;
   assign bus.max_out      = max;
   assign bus.count_out    = count;

endmodule

// File: tb/tb_block_accumulator.sv
// Directed bench for block_accumulator: a table of block patterns with
// hand-computed results, plus hand-written hold, reset and drop sequences.
module tb_block_accumulator;

   localparam int LOGDEPTH = 6;
   localparam int WIDTH    = 32;
   localparam int TIMEOUT  = 16;
   localparam int N        = 1 << LOGDEPTH;

   typedef struct {
      int          nwords;
      logic [31:0] base;
      int          step;
      int          gap;
      bit          junk;
      logic [37:0] exp_sum;
      logic [31:0] exp_max;
      int          exp_cnt;
      bit          exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nfail = 0;
   int   en_count = 0;
   vec_t vecs[7];

   block_accumulator_if #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH)) bus ();

   block_accumulator #(
      .LOGDEPTH (LOGDEPTH),
      .WIDTH    (WIDTH),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Count EN_blockRead cycles, sampled mid-cycle.
   always @(negedge clk)
      if (bus.EN_blockRead) en_count++;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},  64'(bus.busy), 64'd0);
      check({tag, "_en"},    64'(bus.EN_blockRead), 64'd0);
      check({tag, "_rv"},    64'(bus.result_valid), 64'd0);
      check({tag, "_err"},   64'(bus.err_short), 64'd0);
      check({tag, "_sum"},   64'(bus.sum_out), 64'd0);
      check({tag, "_max"},   64'(bus.max_out), 64'd0);
      check({tag, "_count"}, 64'(bus.count_out), 64'd0);
   endtask

   task automatic do_block(input vec_t v, input bit release_it);
      int cyc, bound, en0;
      logic [31:0] d;
      en0 = en_count;
      bus.start = 1'b1;
      tick; cyc = 1;
      bus.start = 1'b0;
      check("req_busy", 64'(bus.busy), 64'd1);
      check("req_en",   64'(bus.EN_blockRead), 64'd1);
      if (v.junk) begin
         bus.VALID_memVal = 1'b1;
         bus.memVal_data  = 32'hFFFF_FFFF;
      end
      tick; cyc++;
      bus.VALID_memVal = 1'b0;
      check("en_width", 64'(bus.EN_blockRead), 64'd0);
      for (int i = 0; i < v.nwords; i++) begin
         repeat (v.gap) begin tick; cyc++; end
         d = v.base + 32'(i * v.step);
         bus.VALID_memVal = 1'b1;
         bus.memVal_data  = d;
         tick; cyc++;
         bus.VALID_memVal = 1'b0;
      end
      bound = 0;
      while (!bus.result_valid && bound < 64) begin
         tick; cyc++; bound++;
      end
      check("idle_wait", 64'(bound), (v.nwords < N) ? 64'(TIMEOUT) : 64'd0);
      if (v.gap == 0 && v.nwords == N)
         check("latency", 64'(cyc), 64'(N + 2));
      check("rv",    64'(bus.result_valid), 64'd1);
      check("sum",   64'(bus.sum_out), 64'(v.exp_sum));
      check("max",   64'(bus.max_out), 64'(v.exp_max));
      check("count", 64'(bus.count_out), 64'(v.exp_cnt));
      check("err",   64'(bus.err_short), 64'(v.exp_err));
      check("en_pulses", 64'(en_count - en0), 64'd1);
      if (release_it) begin
         bus.result_ready = 1'b1;
         tick;
         bus.result_ready = 1'b0;
         check("rel_busy", 64'(bus.busy), 64'd0);
         check("rel_rv",   64'(bus.result_valid), 64'd0);
      end
   endtask

   initial begin
      int en0;
      vecs[0] = '{64, 32'd1,          1, 0, 1'b0, 38'd2080,          32'd64,          64, 1'b0};
      vecs[1] = '{64, 32'hFFFF_FFFF,  0, 0, 1'b0, 38'h3F_FFFF_FFC0,  32'hFFFF_FFFF,   64, 1'b0};
      vecs[2] = '{64, 32'd5,          0, 3, 1'b0, 38'd320,           32'd5,           64, 1'b0};
      vecs[3] = '{10, 32'd7,          0, 0, 1'b0, 38'd70,            32'd7,           10, 1'b1};
      vecs[4] = '{64, 32'd64,        -1, 0, 1'b1, 38'd2080,          32'd64,          64, 1'b0};
      vecs[5] = '{0,  32'd0,          0, 0, 1'b0, 38'd0,             32'd0,           0,  1'b1};
      vecs[6] = '{63, 32'd1,          0, 0, 1'b0, 38'd63,            32'd1,           63, 1'b1};

      rst = 1'b1;
      bus.start        = 1'b0;
      bus.VALID_memVal = 1'b0;
      bus.memVal_data  = '0;
      bus.result_ready = 1'b0;
      repeat (3) tick;
      check_idle_zero("reset");
      rst = 1'b0;
      tick;

      for (int k = 0; k < 7; k++)
         do_block(vecs[k], 1'b1);

      // Hold in DONE with the consumer stalled; start pulses must not stick.
      do_block(vecs[0], 1'b0);
      en0 = en_count;
      for (int k = 0; k < 20; k++) begin
         bus.start = (k % 4 == 0);
         tick;
         check("hold_rv",  64'(bus.result_valid), 64'd1);
         check("hold_sum", 64'(bus.sum_out), 64'd2080);
      end
      bus.start = 1'b0;
      check("hold_max",   64'(bus.max_out), 64'd64);
      check("hold_count", 64'(bus.count_out), 64'd64);
      check("hold_en",    64'(en_count - en0), 64'd0);
      bus.result_ready = 1'b1;
      bus.start        = 1'b1;
      tick;
      bus.result_ready = 1'b0;
      bus.start        = 1'b0;
      check("rdy_start_busy", 64'(bus.busy), 64'd0);
      check("rdy_start_rv",   64'(bus.result_valid), 64'd0);
      tick;
      check("rdy_start_idle", 64'(bus.busy), 64'd0);
      check("rdy_start_en",   64'(en_count - en0), 64'd0);

      // Reset in the middle of a block discards it.
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      tick;
      for (int i = 1; i <= 30; i++) begin
         bus.VALID_memVal = 1'b1;
         bus.memVal_data  = 32'(i);
         tick;
      end
      check("mid_count", 64'(bus.count_out), 64'd30);
      en0 = en_count;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      bus.VALID_memVal = 1'b0;
      check_idle_zero("midrst");
      tick;
      check("midrst_en", 64'(en_count - en0), 64'd0);
      do_block(vecs[0], 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
